// File: rtl/ins_cyc_ctrl.sv
// Instruction-cycle controller for the 8-bit lab processor: fetch/decode/execute FSM driving datapath strobes.
// Optional single-step mode (Step input + PAUSE state) is enabled by defining CTRL_SINGLE_STEP_EN.
//
// state  | meaning
// START  | post-reset idle, all outputs 0
// FETCH  | load IR from memory[PC], PC <= PC+1
// DECODE | address memory with IR[4:0], pick execute state from opcode
// LOAD   | A <= memory data
// STORE  | memory <= A
// ADD    | A <= A + memory data
// SUB    | A <= A - memory data
// INPUT  | wait for Enter, then A <= input port
// JZ     | PC <= IR[4:0] when A == 0
// JPOS   | PC <= IR[4:0] when A > 0
// HALT   | drive A onto output port until reset
// PAUSE  | single-step hold between instructions (CTRL_SINGLE_STEP_EN only)
module ins_cyc_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       Step,
`endif
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Outen,
  output logic       Halt
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
`ifdef CTRL_SINGLE_STEP_EN
    , S_PAUSE = 4'd11
`endif
  } state_t;

  // Where every non-halting execute state goes once its work is done.
`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t EXEC_NEXT = S_PAUSE;
`else
  localparam state_t EXEC_NEXT = S_FETCH;
`endif

  state_t state;
  state_t next_state;

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_START;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_START;
    case (state)
      S_START:  next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (IR)
          3'b000:  next_state = S_LOAD;
          3'b001:  next_state = S_STORE;
          3'b010:  next_state = S_ADD;
          3'b011:  next_state = S_SUB;
          3'b100:  next_state = S_INPUT;
          3'b101:  next_state = S_JZ;
          3'b110:  next_state = S_JPOS;
          default: next_state = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: next_state = EXEC_NEXT;
      S_INPUT:  next_state = Enter ? EXEC_NEXT : S_INPUT;
      S_HALT:   next_state = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE:  next_state = Step ? S_FETCH : S_PAUSE;
`endif
      default:  next_state = S_START;
    endcase
  end

  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = 2'b00;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Outen   = 1'b0;
    Halt    = 1'b0;
    case (state)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = 2'b01;
        Aload = Enter;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT: begin
        Halt  = 1'b1;
        Outen = 1'b1;
      end
      default: ;
    endcase
    // Reset must quiet the datapath in the same cycle, not one edge later.
    if (Reset) begin
      IRload  = 1'b0;
      PCload  = 1'b0;
      JMPmux  = 1'b0;
      Meminst = 1'b0;
      MemWr   = 1'b0;
      Asel    = 2'b00;
      Aload   = 1'b0;
      Sub     = 1'b0;
      Outen   = 1'b0;
      Halt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ins_cyc_ctrl.sv
// Self-checking bench for ins_cyc_ctrl: directed and random instruction streams checked cycle by cycle
// against an instruction-level model of the expected output strobes.
module tb_ins_cyc_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] IR;
  logic       Aeq0, Apos, Enter;
`ifdef CTRL_SINGLE_STEP_EN
  logic       Step;
`endif
  logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Outen, Halt;
  logic [1:0] Asel;

  int compared = 0;
  int mismatched = 0;

  logic [10:0] obs;
  assign obs = {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Outen, Halt};

  always #5 Clock = ~Clock;

  ins_cyc_ctrl dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
`ifdef CTRL_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst), .MemWr(MemWr),
    .Asel(Asel), .Aload(Aload), .Sub(Sub), .Outen(Outen), .Halt(Halt)
  );

  function automatic logic [10:0] vec(input logic irl, pcl, jmp, mi, mw, input logic [1:0] as,
                                       input logic al, sb, oe, h);
    return {irl, pcl, jmp, mi, mw, as, al, sb, oe, h};
  endfunction

  localparam logic [10:0] ZERO   = 11'b0;
  localparam logic [10:0] FETCH  = 11'b110_0000_0000;
  localparam logic [10:0] DECODE = 11'b000_1000_0000;

  // Expected outputs for the execute cycle of an opcode, straight from the opcode table.
  function automatic logic [10:0] exec_vec(input logic [2:0] op, input logic en, z, p);
    case (op)
      3'd0:    return vec(0, 0, 0, 1, 0, 2'b10, 1,  0, 0, 0);
      3'd1:    return vec(0, 0, 0, 1, 1, 2'b00, 0,  0, 0, 0);
      3'd2:    return vec(0, 0, 0, 1, 0, 2'b00, 1,  0, 0, 0);
      3'd3:    return vec(0, 0, 0, 1, 0, 2'b00, 1,  1, 0, 0);
      3'd4:    return vec(0, 0, 0, 0, 0, 2'b01, en, 0, 0, 0);
      3'd5:    return vec(0, z, 1, 0, 0, 2'b00, 0,  0, 0, 0);
      3'd6:    return vec(0, p, 1, 0, 0, 2'b00, 0,  0, 0, 0);
      default: return vec(0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 1);
    endcase
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare just after.
  task automatic cyc(input logic rst, input logic [2:0] ir, input logic en, z, p,
                     input logic [10:0] exp, input string tag);
    @(negedge Clock);
    Reset = rst; IR = ir; Enter = en; Aeq0 = z; Apos = p;
    #1;
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom);
  endfunction

  task automatic run_instr(input logic [2:0] op, input logic z, p, input int nwait);
    logic en;
    cyc(0, rop(), rb(), rb(), rb(), FETCH, "fetch");
    cyc(0, op, rb(), rb(), rb(), DECODE, "decode");
    if (op == 3'd4) begin
      for (int i = 0; i < nwait; i++)
        cyc(0, rop(), 1'b0, rb(), rb(), exec_vec(op, 1'b0, 1'b0, 1'b0), "in_wait");
      cyc(0, rop(), 1'b1, rb(), rb(), exec_vec(op, 1'b1, 1'b0, 1'b0), "in_load");
    end else begin
      en = rb();
      cyc(0, rop(), en, z, p, exec_vec(op, en, z, p), "exec");
    end
`ifdef CTRL_SINGLE_STEP_EN
    if (op != 3'd7) begin
      Step = 1'b0;
      for (int i = 0; i < 2; i++) cyc(0, rop(), rb(), rb(), rb(), ZERO, "pause");
      Step = 1'b1;
      cyc(0, rop(), rb(), rb(), rb(), ZERO, "pause_step");
      Step = rb();
    end
`endif
  endtask

  initial begin
    Reset = 1'b1; IR = 3'd0; Enter = 1'b0; Aeq0 = 1'b0; Apos = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    Step = 1'b0;
`endif
    for (int i = 0; i < 3; i++) cyc(1, rop(), rb(), rb(), rb(), ZERO, "reset");
    cyc(0, rop(), rb(), rb(), rb(), ZERO, "start");

    run_instr(3'd0, 1'b0, 1'b0, 0);
    run_instr(3'd1, 1'b0, 1'b0, 0);
    run_instr(3'd2, 1'b1, 1'b1, 0);
    run_instr(3'd3, 1'b0, 1'b1, 0);
    run_instr(3'd5, 1'b1, 1'b0, 0);
    run_instr(3'd5, 1'b0, 1'b1, 0);
    run_instr(3'd6, 1'b0, 1'b1, 0);
    run_instr(3'd6, 1'b1, 1'b0, 0);
    run_instr(3'd4, 1'b0, 1'b0, 4);
    run_instr(3'd4, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++)
      run_instr(3'($urandom_range(0, 6)), rb(), rb(), int'($urandom_range(0, 3)));

    // Reset mid-instruction in an execute cycle
    cyc(0, rop(), rb(), rb(), rb(), FETCH, "fetch");
    cyc(0, 3'd2, rb(), rb(), rb(), DECODE, "decode");
    cyc(1, rop(), rb(), rb(), rb(), ZERO, "rst_exec");
    cyc(0, rop(), rb(), rb(), rb(), ZERO, "start_after_exec_rst");

    // Reset while waiting for Enter
    cyc(0, rop(), rb(), rb(), rb(), FETCH, "fetch");
    cyc(0, 3'd4, rb(), rb(), rb(), DECODE, "decode");
    cyc(0, rop(), 1'b0, rb(), rb(), exec_vec(3'd4, 1'b0, 1'b0, 1'b0), "in_wait");
    cyc(1, rop(), 1'b1, rb(), rb(), ZERO, "rst_input");
    cyc(0, rop(), rb(), rb(), rb(), ZERO, "start_after_in_rst");

    // HALT persists, only reset leaves it
    cyc(0, rop(), rb(), rb(), rb(), FETCH, "fetch");
    cyc(0, 3'd7, rb(), rb(), rb(), DECODE, "decode");
    for (int i = 0; i < 20; i++)
      cyc(0, rop(), rb(), rb(), rb(), exec_vec(3'd7, 1'b0, 1'b0, 1'b0), "halt");
    cyc(1, rop(), rb(), rb(), rb(), ZERO, "rst_halt");
    cyc(0, rop(), rb(), rb(), rb(), ZERO, "start_after_halt");
    run_instr(3'd0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
